// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes and the request driver state encoding.
package calc1_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, DONE} state_t;

endpackage

// File: rtl/calc1_req_timer.sv
// 8-bit loadable down-counter; expired is high while the count sits at zero.
module calc1_req_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 8'd1;
  end

  assign expired = (count == 8'd0);

endmodule

// File: rtl/calc1_req_driver.sv
// Single-port calc1 request initiator: client op in, two-cycle port sequence out,
// response (or timeout) back to the client. Every output is a flop.
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        cl_valid,
  output logic        cl_ready,
  input  logic [0:3]  cl_cmd,
  input  logic [0:31] cl_op1,
  input  logic [0:31] cl_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic        late_resp,
  output logic [0:3]  req_cmd_in,
  output logic [0:31] req_data_in,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data
);

  state_t      state, nxt_state;
  logic [0:31] op2_q;
  logic [0:3]  nxt_req_cmd;
  logic [0:31] nxt_req_data, nxt_rsp_data;
  logic [0:1]  nxt_rsp_resp;
  logic        nxt_rsp_valid, nxt_rsp_timeout;
  logic        tmr_load, tmr_dec, tmr_expired;
  logic        accept;

  assign accept = (state == IDLE) && cl_valid && cl_ready;

  calc1_req_timer u_timer (
    .clk      (c_clk),
    .rst      (reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (8'(TIMEOUT_CYCLES)),
    .expired  (tmr_expired)
  );

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  // Port outputs are computed for the state being entered so they appear
  // in the same cycle the FSM occupies SEND1/SEND2.
  always_comb begin
    nxt_state       = state;
    nxt_req_cmd     = CMD_NOP;
    nxt_req_data    = '0;
    nxt_rsp_valid   = rsp_valid;
    nxt_rsp_resp    = rsp_resp;
    nxt_rsp_data    = rsp_data;
    nxt_rsp_timeout = rsp_timeout;
    tmr_load        = 1'b0;
    tmr_dec         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cl_cmd == CMD_NOP) begin
            nxt_state       = DONE;
            nxt_rsp_valid   = 1'b1;
            nxt_rsp_resp    = RESP_ERR;
            nxt_rsp_data    = '0;
            nxt_rsp_timeout = 1'b0;
          end else begin
            nxt_state    = SEND1;
            nxt_req_cmd  = cl_cmd;
            nxt_req_data = cl_op1;
          end
        end
      end
      SEND1: begin
        nxt_state    = SEND2;
        nxt_req_data = op2_q;
      end
      SEND2: begin
        nxt_state = WAIT;
        tmr_load  = 1'b1;
      end
      WAIT: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (out_resp != RESP_NONE) begin
          nxt_state       = DONE;
          nxt_rsp_valid   = 1'b1;
          nxt_rsp_resp    = out_resp;
          nxt_rsp_data    = out_data;
          nxt_rsp_timeout = 1'b0;
        end else if (tmr_expired) begin
          nxt_state       = DONE;
          nxt_rsp_valid   = 1'b1;
          nxt_rsp_resp    = RESP_NONE;
          nxt_rsp_data    = '0;
          nxt_rsp_timeout = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          nxt_state     = IDLE;
          nxt_rsp_valid = 1'b0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cl_ready    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      late_resp   <= 1'b0;
      req_cmd_in  <= '0;
      req_data_in <= '0;
      op2_q       <= '0;
    end else begin
      cl_ready    <= (nxt_state == IDLE);
      rsp_valid   <= nxt_rsp_valid;
      rsp_resp    <= nxt_rsp_resp;
      rsp_data    <= nxt_rsp_data;
      rsp_timeout <= nxt_rsp_timeout;
      req_cmd_in  <= nxt_req_cmd;
      req_data_in <= nxt_req_data;
      if (out_resp != RESP_NONE && state != WAIT) late_resp <= 1'b1;
      if (accept) op2_q <= cl_op2;
    end
  end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed + randomized bench for calc1_req_driver with a behavioural calc1 stub.
module tb_calc1_req_driver;

  localparam int T = 8;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cl_valid = 1'b0, rsp_ready = 1'b0;
  logic [0:3]  cl_cmd = '0;
  logic [0:31] cl_op1 = '0, cl_op2 = '0, out_data = '0;
  logic [0:1]  out_resp = '0;
  logic        cl_ready, rsp_valid, rsp_timeout, late_resp;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data, req_data_in;
  logic [0:3]  req_cmd_in;

  int checks = 0;
  int failures = 0;

  calc1_req_driver #(.TIMEOUT_CYCLES(T)) dut (
    .c_clk(c_clk), .reset(reset), .cl_valid(cl_valid), .cl_ready(cl_ready),
    .cl_cmd(cl_cmd), .cl_op1(cl_op1), .cl_op2(cl_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .late_resp(late_resp),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data)
  );

  always #5 c_clk = ~c_clk;

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a calc1 port would answer for a given command.
  function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               output logic [1:0] r, output logic [31:0] d);
    logic [32:0] s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        if (!s[32]) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << b[4:0]; end
      4'd6: begin r = 2'd1; d = a >> b[4:0]; end
      default: ;
    endcase
  endfunction

  // dly < 0 : stub stays silent (timeout expected); otherwise respond dly cycles into WAIT.
  // late_at : hold-cycle index at which the stub emits a stray response in DONE (-1 = never).
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input int dly, input int hold, input int late_at);
    logic [1:0]  er;
    logic [31:0] ed;
    logic        eto;
    eto = 1'b0;
    if (cmd == 4'd0) begin er = 2'd2; ed = 32'd0; end
    else if (dly < 0) begin er = 2'd0; ed = 32'd0; eto = 1'b1; end
    else calc(cmd, a, b, er, ed);

    chk("idle_ready", cl_ready, 1);
    cl_valid = 1'b1; cl_cmd = cmd; cl_op1 = a; cl_op2 = b;
    step();
    cl_valid = 1'b0; cl_cmd = 4'($urandom); cl_op1 = $urandom; cl_op2 = $urandom;
    chk("busy_ready", cl_ready, 0);
    if (cmd != 4'd0) begin
      chk("send1_cmd", req_cmd_in, cmd);
      chk("send1_data", req_data_in, a);
      step();
      chk("send2_cmd", req_cmd_in, 0);
      chk("send2_data", req_data_in, b);
      step();
      chk("wait_cmd", req_cmd_in, 0);
      chk("wait_data", req_data_in, 0);
      if (dly < 0) begin
        repeat (T) step();
        chk("no_early_timeout", rsp_valid, 0);
        step();
      end else begin
        repeat (dly) step();
        chk("no_early_rsp", rsp_valid, 0);
        out_resp = er; out_data = ed;
        step();
        out_resp = 2'd0; out_data = $urandom;
      end
    end else begin
      chk("nop_port_cmd", req_cmd_in, 0);
      chk("nop_port_data", req_data_in, 0);
    end
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_resp", rsp_resp, er);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_timeout", rsp_timeout, eto);
      if (i < hold) begin
        chk("hold_ready", cl_ready, 0);
        if (i == late_at) out_resp = 2'd2;
        step();
        out_resp = 2'd0;
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("loopback_ready", cl_ready, 1);
  endtask

  logic [3:0] cmds [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd15};

  initial begin
    #2;
    chk("rst_ready", cl_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_cmd", req_cmd_in, 0);
    chk("rst_late", late_resp, 0);
    step();
    reset = 1'b0;
    step();

    do_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 3, 0, -1);
    do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, -1);
    do_op(4'd2, 32'd1, 32'd15, 2, 0, -1);
    do_op(4'd1, 32'd5, 32'd6, T, 0, -1);
    do_op(4'd1, 32'd7, 32'd8, 1, 5, -1);
    do_op(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, -1);
    do_op(4'd5, 32'h0000_00F1, 32'd4, 1, 0, -1);
    do_op(4'd6, 32'h8000_0000, 32'd31, 2, 0, -1);
    do_op(4'd3, 32'd9, 32'd9, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      int d;
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      d = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, T);
      do_op(cmds[$urandom_range(0, 9)], a, b, d, $urandom_range(0, 3), -1);
    end
    chk("late_clear", late_resp, 0);

    do_op(4'd1, 32'd1, 32'd2, -1, 4, 2);
    chk("late_set", late_resp, 1);
    do_op(4'd2, 32'd20, 32'd5, 1, 0, -1);
    chk("late_sticky", late_resp, 1);

    cl_valid = 1'b1; cl_cmd = 4'd1; cl_op1 = 32'd2; cl_op2 = 32'd3;
    step();
    cl_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("arst_ready", cl_ready, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_resp", rsp_resp, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_timeout", rsp_timeout, 0);
    chk("arst_late", late_resp, 0);
    chk("arst_cmd", req_cmd_in, 0);
    chk("arst_pdata", req_data_in, 0);
    step();
    reset = 1'b0;
    step();
    do_op(4'd1, 32'd2, 32'd3, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
